uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_pkg.sv | 29 ++
 rtl/uart_cts_sync.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
//   Shared types and constants for the UART TX arbiter slice.
//   owner_t     : current lock holder (NONE=0, KBD=1, RPT=2)
//   arb_state_t : arbiter FSM states
//   TIMEOUT_CYC_DEF : default stall limit before a lock is forcibly released
//   cnt_width() : stall-counter width, never narrower than 17 bits
package uart_tx_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    KBD  = 2'd1,
    RPT  = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam int unsigned TIMEOUT_CYC_DEF = 100000;

  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w > 17) ? w : 17;
  endfunction

endpackage

// File: rtl/uart_cts_sync.sv
// uart_cts_sync
//   Two-flop synchronizer for the active-low UART clear-to-send input.
//   Both flops reset to 1 so the transmitter starts out blocked.
//   i_clk   : sampling clock
//   i_rst_n : synchronous reset, active-low
//   i_async : asynchronous cts_n from the UART pin
//   o_sync  : cts_n resynchronized to i_clk
module uart_cts_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Packet-level arbiter sharing one UART transmitter between a keyboard
//   byte stream and a terminal-report byte stream. A requester keeps the
//   lock until the byte flagged last is accepted, so packets never
//   interleave. Ties in IDLE go to the requester not served last. A lock
//   whose owner stops offering bytes mid-packet is dropped after
//   TIMEOUT_CYC idle cycles.
//
//   Optional feature: define UART_TX_CTS_EN to add the cts_n port, which is
//   synchronized and gates new acceptances. Without it, CTS is always OK.
//
//   Ports
//     clk100M   in   sole clock
//     rst_n     in   synchronous reset, active-low
//     kbd_data  in   keyboard byte;       kbd_last ends packet
//     kbd_valid in   keyboard byte offered; kbd_ready out: accepted this cycle
//     rpt_data  in   report byte;         rpt_last ends packet
//     rpt_valid in   report byte offered; rpt_ready out: accepted this cycle
//     tx_data   out  byte to UART transmitter (held between launches)
//     tx_start  out  one-cycle launch pulse
//     tx_busy   in   transmitter busy, high from cycle after tx_start
//     owner     out  current lock: 0 none, 1 kbd, 2 rpt
//     timeout   out  one-cycle pulse on forced release
//     cts_n     in   clear-to-send, active-low (UART_TX_CTS_EN only)
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk100M,
  input  logic       rst_n,
  input  logic [7:0] kbd_data,
  input  logic       kbd_last,
  input  logic       kbd_valid,
  output logic       kbd_ready,
  input  logic [7:0] rpt_data,
  input  logic       rpt_last,
  input  logic       rpt_valid,
  output logic       rpt_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [1:0] owner,
  output logic       timeout
`ifdef UART_TX_CTS_EN
  ,
  input  logic       cts_n
`endif
);

  localparam int unsigned       CNT_W   = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t       r_state;
  owner_t           r_owner;
  owner_t           r_last_served;
  logic [7:0]       r_tx_data;
  logic             r_tx_start;
  logic             r_timeout;
  logic             r_pkt_end;
  logic [CNT_W-1:0] r_idle_cnt;

  logic       w_cts_ok;
  logic       w_own_valid;
  logic [7:0] w_own_data;
  logic       w_own_last;
  logic       w_grant;
  logic       w_hs;

`ifdef UART_TX_CTS_EN
  logic w_cts_n_sync;

  uart_cts_sync u_cts_sync (
    .i_clk   (clk100M),
    .i_rst_n (rst_n),
    .i_async (cts_n),
    .o_sync  (w_cts_n_sync)
  );

  assign w_cts_ok = ~w_cts_n_sync;
`else
  assign w_cts_ok = 1'b1;
`endif

  // Select the lock holder's request lines.
  always_comb begin
    w_own_valid = 1'b0;
    w_own_data  = '0;
    w_own_last  = 1'b0;
    case (r_owner)
      KBD: begin
        w_own_valid = kbd_valid;
        w_own_data  = kbd_data;
        w_own_last  = kbd_last;
      end
      RPT: begin
        w_own_valid = rpt_valid;
        w_own_data  = rpt_data;
        w_own_last  = rpt_last;
      end
      default: begin
        w_own_valid = 1'b0;
        w_own_data  = '0;
        w_own_last  = 1'b0;
      end
    endcase
  end

  // Ready is gated by rst_n so no upstream handshake is seen on a reset edge.
  assign w_grant   = rst_n && (r_state == GRANT);
  assign kbd_ready = w_grant && (r_owner == KBD) && kbd_valid && !tx_busy && w_cts_ok;
  assign rpt_ready = w_grant && (r_owner == RPT) && rpt_valid && !tx_busy && w_cts_ok;
  assign w_hs      = kbd_ready || rpt_ready;

  always_ff @(posedge clk100M) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_owner       <= NONE;
      r_last_served <= KBD;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_timeout     <= 1'b0;
      r_pkt_end     <= 1'b0;
      r_idle_cnt    <= '0;
    end else begin
      r_tx_start <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (kbd_valid && rpt_valid) begin
            r_owner <= (r_last_served == KBD) ? RPT : KBD;
            r_state <= GRANT;
          end else if (kbd_valid) begin
            r_owner <= KBD;
            r_state <= GRANT;
          end else if (rpt_valid) begin
            r_owner <= RPT;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_hs) begin
            r_tx_data  <= w_own_data;
            r_tx_start <= 1'b1;
            r_pkt_end  <= w_own_last;
            r_idle_cnt <= '0;
            r_state    <= GAP;
          end else if (!w_own_valid) begin
            // Only a silent owner stalls the lock; busy/CTS back-pressure does not.
            if (r_idle_cnt == CNT_MAX) begin
              r_timeout     <= 1'b1;
              r_last_served <= r_owner;
              r_owner       <= NONE;
              r_idle_cnt    <= '0;
              r_state       <= IDLE;
            end else begin
              r_idle_cnt <= r_idle_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          // One dead cycle lets tx_busy rise before the next acceptance.
          if (r_pkt_end) begin
            r_last_served <= r_owner;
            r_owner       <= NONE;
            r_state       <= IDLE;
          end else begin
            r_state <= GRANT;
          end
        end
        default: begin
          r_state <= IDLE;
          r_owner <= NONE;
        end
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign owner    = r_owner;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic       clk100M = 1'b0;
  logic       rst_n;
  logic [7:0] kbd_data, rpt_data;
  logic       kbd_last, rpt_last;
  logic       kbd_valid, rpt_valid;
  logic       kbd_ready, rpt_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [1:0] owner;
  logic       timeout;
  logic       cts_n;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] own;
  } exp_t;

  exp_t exp_q[$];
  int   total      = 0;
  int   bad        = 0;
  int   tmo_expect = 0;
  int   busy_len   = 2;

  always #5 clk100M = ~clk100M;

  uart_tx_arbiter #(.TIMEOUT_CYC(16)) dut (
    .clk100M   (clk100M),
    .rst_n     (rst_n),
    .kbd_data  (kbd_data),
    .kbd_last  (kbd_last),
    .kbd_valid (kbd_valid),
    .kbd_ready (kbd_ready),
    .rpt_data  (rpt_data),
    .rpt_last  (rpt_last),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .owner     (owner),
    .timeout   (timeout)
`ifdef UART_TX_CTS_EN
    ,
    .cts_n     (cts_n)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] o);
    exp_t e;
    e.data = d;
    e.own  = o;
    exp_q.push_back(e);
  endtask

  // Offer one byte on src (0=kbd, 1=rpt) and wait for its handshake.
  task automatic send_byte(input int src, input logic [7:0] d, input logic l);
    bit got;
    got = 1'b0;
    if (src == 0) begin kbd_data = d; kbd_last = l; kbd_valid = 1'b1; end
    else          begin rpt_data = d; rpt_last = l; rpt_valid = 1'b1; end
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk100M);
      if ((src == 0) ? kbd_ready : rpt_ready) got = 1'b1;
      @(posedge clk100M);
      #1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL handshake src=%0d data=%h actual=none required=accepted", src, d);
    end
    if (src == 0) kbd_valid = 1'b0;
    else          rpt_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk100M);
    #1 rst_n = 1'b1;
  endtask

  // Transmitter model: busy from the cycle after tx_start for busy_len cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk100M);
      if (tx_start && busy_len > 0) begin
        @(posedge clk100M);
        #1 tx_busy = 1'b1;
        repeat (busy_len) @(posedge clk100M);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Monitor: every launch is popped against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk100M);
      if (tx_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_tx_start actual=%h required=no_launch t=%0t", tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", {24'h0, tx_data}, {24'h0, e.data});
          check("tx_owner", {30'h0, owner}, {30'h0, e.own});
        end
      end
      if (timeout === 1'b1) begin
        total++;
        if (tmo_expect > 0) tmo_expect--;
        else begin
          bad++;
          $display("FAIL unexpected_timeout actual=1 required=0 t=%0t", $time);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; cts_n = 1'b1;
    kbd_data = '0; kbd_last = 1'b0; kbd_valid = 1'b1;
    rpt_data = '0; rpt_last = 1'b0; rpt_valid = 1'b1;

    // Reset state, with both requesters asserting valid.
    repeat (3) @(posedge clk100M);
    #1;
    check("rst_tx_start", {31'h0, tx_start}, 0);
    check("rst_owner", {30'h0, owner}, 0);
    check("rst_tx_data", {24'h0, tx_data}, 0);
    check("rst_timeout", {31'h0, timeout}, 0);
    check("rst_kbd_ready", {31'h0, kbd_ready}, 0);
    check("rst_rpt_ready", {31'h0, rpt_ready}, 0);
    kbd_valid = 1'b0; rpt_valid = 1'b0;
    rst_n = 1'b1;
`ifndef UART_TX_CTS_EN
    // Keyboard packet 1B 5B 41, 10-cycle transmitter.
    busy_len = 10;
    push(8'h1B, 2'd1); push(8'h5B, 2'd1); push(8'h41, 2'd1);
    send_byte(0, 8'h1B, 1'b0);
    check("kbd_owner_mid", {30'h0, owner}, 1);
    send_byte(0, 8'h5B, 1'b0);
    send_byte(0, 8'h41, 1'b1);
    repeat (15) @(posedge clk100M);
    #1;
    check("kbd_owner_after", {30'h0, owner}, 0);
    check("tx_data_hold", {24'h0, tx_data}, 32'h41);
    check("kbd_q_empty", exp_q.size(), 0);

    // Tie after reset: report wins, then kbd, then the next tie goes to kbd.
    do_reset();
    busy_len = 2;
    push(8'h1B, 2'd2); push(8'h5B, 2'd2); push(8'h30, 2'd2); push(8'h6E, 2'd2);
    push(8'h61, 2'd1);
    push(8'h1B, 2'd2); push(8'h63, 2'd2);
    fork
      begin
        send_byte(1, 8'h1B, 1'b0);
        send_byte(1, 8'h5B, 1'b0);
        send_byte(1, 8'h30, 1'b0);
        send_byte(1, 8'h6E, 1'b1);
        send_byte(1, 8'h1B, 1'b0);
        send_byte(1, 8'h63, 1'b1);
      end
      send_byte(0, 8'h61, 1'b1);
    join
    repeat (8) @(posedge clk100M);
    #1;
    check("rr_q_empty", exp_q.size(), 0);

    // Long busy back-pressure with valid high must not trip the timeout.
    busy_len = 30;
    push(8'h71, 2'd1); push(8'h72, 2'd1);
    send_byte(0, 8'h71, 1'b0);
    send_byte(0, 8'h72, 1'b1);
    repeat (35) @(posedge clk100M);
    #1;
    check("busy_q_empty", exp_q.size(), 0);

    // Report stalls mid-packet: forced release, then pending kbd byte.
    do_reset();
    busy_len = 2;
    tmo_expect = 1;
    push(8'h1B, 2'd2); push(8'h62, 2'd1);
    fork
      begin
        send_byte(1, 8'h1B, 1'b0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
          @(posedge clk100M);
          #1;
          n++;
          if (timeout) break;
        end
        check("tmo_latency", n, 17);
        check("tmo_owner", {30'h0, owner}, 0);
        @(posedge clk100M);
        #1;
        check("tmo_pulse_width", {31'h0, timeout}, 0);
      end
      send_byte(0, 8'h62, 1'b1);
    join
    repeat (6) @(posedge clk100M);
    #1;
    check("tmo_q_empty", exp_q.size(), 0);

    // Reset one cycle after the 2nd byte of a 3-byte packet.
    push(8'h31, 2'd1); push(8'h32, 2'd1);
    send_byte(0, 8'h31, 1'b0);
    send_byte(0, 8'h32, 1'b0);
    rst_n = 1'b0;
    kbd_data = 8'h33; kbd_last = 1'b1; kbd_valid = 1'b1;
    @(posedge clk100M);
    #1;
    check("mid_rst_tx_start", {31'h0, tx_start}, 0);
    check("mid_rst_owner", {30'h0, owner}, 0);
    check("mid_rst_tx_data", {24'h0, tx_data}, 0);
    check("mid_rst_timeout", {31'h0, timeout}, 0);
    check("mid_rst_kbd_ready", {31'h0, kbd_ready}, 0);
    kbd_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk100M);
    #1;
    push(8'h81, 2'd1); push(8'h82, 2'd1); push(8'h83, 2'd1);
    send_byte(0, 8'h81, 1'b0);
    send_byte(0, 8'h82, 1'b0);
    send_byte(0, 8'h83, 1'b1);
    repeat (6) @(posedge clk100M);
    #1;
    check("post_rst_q_empty", exp_q.size(), 0);
`else
    // CTS held off: no acceptance and no timeout, then release.
    do_reset();
    busy_len = 2;
    kbd_data = 8'h41; kbd_last = 1'b1; kbd_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk100M);
      if (kbd_ready) n++;
    end
    check("cts_blocked_ready", n, 0);
    @(posedge clk100M);
    #1;
    push(8'h41, 2'd1);
    cts_n = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk100M);
      #1;
      n++;
      if (tx_start) break;
    end
    check("cts_latency", n, 3);
    kbd_valid = 1'b0;
    repeat (6) @(posedge clk100M);
    #1;
    check("cts_q_empty", exp_q.size(), 0);
    check("cts_owner_after", {30'h0, owner}, 0);
`endif

    repeat (4) @(posedge clk100M);
    #1;
    check("final_q_empty", exp_q.size(), 0);
    check("final_tmo_pending", tmo_expect, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
